// File: rtl/button_ctrl.sv
// Memory-mapped button controller: synchronise, debounce, sticky press events, maskable irq.
// Define BUTTON_CTRL_RELEASE_EVT_EN to add release events and masks in bits [8+N-1:8].
module button_ctrl #(
   parameter int unsigned N_BUTTONS       = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   inout  wire  [15:0]          data_bus,
   input  logic [1:0]           address_bus,
   input  logic                 cs,
   input  logic                 r,
   input  logic                 w,
   input  logic [N_BUTTONS-1:0] buttons,
   output logic                 irq
);

   localparam int unsigned       DATA_W      = 16;
   localparam int unsigned       REL_LSB     = 8;
   localparam logic [DATA_W-1:0] ID_VALUE    = 16'hB7C0;
   localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]        ADDR_LEVEL  = 2'd0;
   localparam logic [1:0]        ADDR_EVENTS = 2'd1;
   localparam logic [1:0]        ADDR_MASK   = 2'd2;
   localparam logic [1:0]        ADDR_ID     = 2'd3;

   logic [N_BUTTONS-1:0] sync1;
   logic [N_BUTTONS-1:0] sync2;
   logic [N_BUTTONS-1:0] stable;
   logic [N_BUTTONS-1:0] stable_nxt;
   logic [CNT_W-1:0]     cnt     [N_BUTTONS];
   logic [CNT_W-1:0]     cnt_nxt [N_BUTTONS];
   logic [N_BUTTONS-1:0] press;
   logic [N_BUTTONS-1:0] press_evt;
   logic [N_BUTTONS-1:0] press_mask;
   logic [N_BUTTONS-1:0] press_clr;
   logic                 wr_events;
   logic                 wr_mask;
   logic                 irq_nxt;
   logic [DATA_W-1:0]    rd_data;
   logic                 unused_wdata;

`ifdef BUTTON_CTRL_RELEASE_EVT_EN
   logic [N_BUTTONS-1:0] rel;
   logic [N_BUTTONS-1:0] rel_evt;
   logic [N_BUTTONS-1:0] rel_mask;
   logic [N_BUTTONS-1:0] rel_clr;
`endif

   assign unused_wdata = ^data_bus;

   // Debounce: accept a new level only after it has disagreed for DEBOUNCE_CYCLES edges
   always_comb begin
      stable_nxt = stable;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
         cnt_nxt[i] = '0;
         if (sync2[i] != stable[i]) begin
            if (cnt[i] == CNT_MAX) begin
               stable_nxt[i] = sync2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign press = stable_nxt & ~stable;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1  <= buttons;
         sync2  <= sync1;
         stable <= stable_nxt;
         for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   assign wr_events = cs & w & (address_bus == ADDR_EVENTS);
   assign wr_mask   = cs & w & (address_bus == ADDR_MASK);
   assign press_clr = wr_events ? data_bus[N_BUTTONS-1:0] : '0;

`ifdef BUTTON_CTRL_RELEASE_EVT_EN
   assign rel     = stable & ~stable_nxt;
   assign rel_clr = wr_events ? data_bus[REL_LSB +: N_BUTTONS] : '0;
   assign irq_nxt = (|(press_evt & press_mask)) | (|(rel_evt & rel_mask));
`else
   assign irq_nxt = |(press_evt & press_mask);
`endif

   // Event flags: a new edge wins over a same-cycle W1C of that bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         press_evt  <= '0;
         press_mask <= '0;
         irq        <= 1'b0;
      end else begin
         press_evt <= (press_evt & ~press_clr) | press;
         if (wr_mask) begin
            press_mask <= data_bus[N_BUTTONS-1:0];
         end
         irq <= irq_nxt;
      end
   end

`ifdef BUTTON_CTRL_RELEASE_EVT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rel_evt  <= '0;
         rel_mask <= '0;
      end else begin
         rel_evt <= (rel_evt & ~rel_clr) | rel;
         if (wr_mask) begin
            rel_mask <= data_bus[REL_LSB +: N_BUTTONS];
         end
      end
   end
`endif

   // Combinational read mux; unused bits read as zero
   always_comb begin
      rd_data = '0;
      unique case (address_bus)
         ADDR_LEVEL:  rd_data[N_BUTTONS-1:0] = stable;
         ADDR_EVENTS: begin
            rd_data[N_BUTTONS-1:0] = press_evt;
`ifdef BUTTON_CTRL_RELEASE_EVT_EN
            rd_data[REL_LSB +: N_BUTTONS] = rel_evt;
`endif
         end
         ADDR_MASK: begin
            rd_data[N_BUTTONS-1:0] = press_mask;
`ifdef BUTTON_CTRL_RELEASE_EVT_EN
            rd_data[REL_LSB +: N_BUTTONS] = rel_mask;
`endif
         end
         ADDR_ID:     rd_data = ID_VALUE;
         default:     rd_data = '0;
      endcase
   end

   assign data_bus = (cs && r) ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl: directed vectors and sequences plus randomized traffic vs a reference model.
module tb_button_ctrl;

   localparam int unsigned NB = 5;
   localparam int unsigned DC = 16;
`ifdef BUTTON_CTRL_RELEASE_EVT_EN
   localparam logic [15:0] VALID = 16'h1F1F;
`else
   localparam logic [15:0] VALID = 16'h001F;
`endif

   logic          clk;
   logic          reset;
   logic          cs;
   logic          r;
   logic          w;
   logic          tb_oe;
   logic [1:0]    addr;
   logic [NB-1:0] buttons;
   logic [15:0]   tb_wdata;
   logic          irq;
   tri1  [15:0]   data_bus;

   assign data_bus = tb_oe ? tb_wdata : 16'bz;

   button_ctrl #(.N_BUTTONS(NB), .DEBOUNCE_CYCLES(DC), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .data_bus(data_bus), .address_bus(addr),
      .cs(cs), .r(r), .w(w), .buttons(buttons), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_en   = 1'b0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a level is accepted once the synchronised input has
   // disagreed with it on DC consecutive clock edges.
   logic [NB-1:0] m_s1, m_s2, m_stable;
   int            m_run [NB];
   logic [15:0]   m_events, m_mask;
   logic          m_irq;

   always @(posedge clk or negedge reset) begin : model
      logic [NB-1:0] st;
      logic [15:0]   ev, mk;
      int            run_n [NB];
      if (!reset) begin
         m_s1 <= '0; m_s2 <= '0; m_stable <= '0;
         m_events <= '0; m_mask <= '0; m_irq <= 1'b0;
         for (int i = 0; i < NB; i++) m_run[i] <= 0;
      end else begin
         st = m_stable; ev = m_events; mk = m_mask;
         for (int i = 0; i < NB; i++) begin
            run_n[i] = (m_s2[i] != m_stable[i]) ? m_run[i] + 1 : 0;
            if (run_n[i] == DC) begin
               st[i] = m_s2[i];
               run_n[i] = 0;
            end
         end
         if (cs && w && addr == 2'd1) ev = ev & ~tb_wdata;
         if (cs && w && addr == 2'd2) mk = tb_wdata & VALID;
         ev = ev | 16'(st & ~m_stable);
`ifdef BUTTON_CTRL_RELEASE_EVT_EN
         ev = ev | (16'(m_stable & ~st) << 8);
`endif
         m_irq    <= |(m_events & m_mask);
         m_events <= ev;
         m_mask   <= mk;
         m_stable <= st;
         m_s1     <= buttons;
         m_s2     <= m_s1;
         for (int i = 0; i < NB; i++) m_run[i] <= run_n[i];
      end
   end

   function automatic logic [15:0] mdl_read(input logic [1:0] a);
      case (a)
         2'd0:    return 16'(m_stable);
         2'd1:    return m_events;
         2'd2:    return m_mask;
         default: return 16'hB7C0;
      endcase
   endfunction

   always @(negedge clk) if (mon_en) chk("irq_vs_model", 16'(irq), 16'(m_irq));

   task automatic rd_now(input string name, input logic [1:0] a, input logic [15:0] exp);
      cs = 1'b1; r = 1'b1; addr = a;
      #1;
      chk(name, data_bus, exp);
      cs = 1'b0; r = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      cs = 1'b1; w = 1'b1; r = 1'b0; addr = a; tb_wdata = d; tb_oe = 1'b1;
      @(posedge clk);
      #1;
      cs = 1'b0; w = 1'b0; tb_oe = 1'b0;
   endtask

   typedef struct {
      logic        cs;
      logic        r;
      logic [1:0]  a;
      logic [15:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [6];
   int   hold [NB];

   initial begin
      vecs[0] = '{1'b1, 1'b1, 2'd0, 16'h0000, "level_after_reset"};
      vecs[1] = '{1'b1, 1'b1, 2'd1, 16'h0000, "events_after_reset"};
      vecs[2] = '{1'b1, 1'b1, 2'd2, 16'h0000, "mask_after_reset"};
      vecs[3] = '{1'b1, 1'b1, 2'd3, 16'hB7C0, "id_read"};
      vecs[4] = '{1'b0, 1'b1, 2'd3, 16'hFFFF, "bus_z_cs0"};
      vecs[5] = '{1'b1, 1'b0, 2'd3, 16'hFFFF, "bus_z_r0"};

      reset = 1'b0; cs = 1'b0; r = 1'b0; w = 1'b0; tb_oe = 1'b0;
      addr = 2'd0; tb_wdata = '0; buttons = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      mon_en = 1'b1;

      // Reset mid-run with pending masked events
      wr(2'd2, 16'h001F);
      @(negedge clk); buttons = 5'b00011;
      repeat (25) @(posedge clk);
      @(negedge clk);
      rd_now("events_before_reset", 2'd1, 16'h0003);
      chk("irq_before_reset", 16'(irq), 16'h0001);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("irq_async_reset", 16'(irq), 16'h0000);
      buttons = '0;
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      foreach (vecs[i]) begin
         @(negedge clk);
         cs = vecs[i].cs; r = vecs[i].r; addr = vecs[i].a;
         #1;
         chk(vecs[i].name, data_bus, vecs[i].exp);
         cs = 1'b0; r = 1'b0;
      end

      // Glitch shorter than the debounce window is rejected
      wr(2'd2, 16'h001F);
      @(negedge clk); buttons[0] = 1'b1;
      repeat (10) @(negedge clk);
      buttons[0] = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      rd_now("glitch_level", 2'd0, 16'h0000);
      rd_now("glitch_events", 2'd1, 16'h0000);
      chk("glitch_irq", 16'(irq), 16'h0000);

      // Clean press: acceptance on edge 18, irq on edge 19
      wr(2'd2, 16'h0004);
      @(negedge clk); buttons[2] = 1'b1;
      repeat (17) @(posedge clk);
      @(negedge clk);
      rd_now("press_level_e17", 2'd0, 16'h0000);
      rd_now("press_events_e17", 2'd1, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      rd_now("press_level_e18", 2'd0, 16'h0004);
      rd_now("press_events_e18", 2'd1, 16'h0004);
      chk("press_irq_e18", 16'(irq), 16'h0000);
      @(posedge clk); #1;
      chk("press_irq_e19", 16'(irq), 16'h0001);
      repeat (21) @(posedge clk);
      @(negedge clk); buttons[2] = 1'b0;
      repeat (25) @(posedge clk);
      @(negedge clk);
      rd_now("release_level", 2'd0, 16'h0000);
      rd_now("release_no_event", 2'd1, 16'h0004);
      wr(2'd1, 16'h001F);
      @(posedge clk); #1;
      chk("irq_after_clear", 16'(irq), 16'h0000);

      // Mask gating
      wr(2'd2, 16'h0000);
      @(negedge clk); buttons[1] = 1'b1;
      repeat (25) @(posedge clk);
      @(negedge clk);
      rd_now("gate_events", 2'd1, 16'h0002);
      chk("gate_irq_masked", 16'(irq), 16'h0000);
      wr(2'd2, 16'h0002);
      chk("gate_irq_write_edge", 16'(irq), 16'h0000);
      @(posedge clk); #1;
      chk("gate_irq_unmasked", 16'(irq), 16'h0001);
      wr(2'd1, 16'h0002);
      rd_now("gate_events_cleared", 2'd1, 16'h0000);
      chk("gate_irq_clear_edge", 16'(irq), 16'h0001);
      @(posedge clk); #1;
      chk("gate_irq_cleared", 16'(irq), 16'h0000);
      @(negedge clk); buttons[1] = 1'b0;
      repeat (25) @(posedge clk);

      // Set/clear collision on the acceptance edge
      @(negedge clk); buttons[3] = 1'b1;
      repeat (17) @(posedge clk);
      wr(2'd1, 16'h0008);
      rd_now("collide_set_wins", 2'd1, 16'h0008);
      wr(2'd1, 16'h0008);
      rd_now("collide_later_clear", 2'd1, 16'h0000);
      @(negedge clk); buttons[3] = 1'b0;
      repeat (25) @(posedge clk);

      // Bus discipline and simultaneous read/write
      wr(2'd2, 16'h0001);
      @(negedge clk);
      cs = 1'b1; r = 1'b0; addr = 2'd2; #1;
      chk("bus_z_no_read", data_bus, 16'hFFFF);
      cs = 1'b0; r = 1'b1; #1;
      chk("bus_z_no_cs", data_bus, 16'hFFFF);
      cs = 1'b1; r = 1'b1; w = 1'b1; tb_wdata = 16'h001F; #1;
      chk("rw_pre_write_value", data_bus, 16'h0001);
      #1;
      r = 1'b0; tb_oe = 1'b1;
      @(posedge clk); #1;
      tb_oe = 1'b0; w = 1'b0; r = 1'b1; #1;
      chk("rw_post_write_value", data_bus, 16'h001F);
      cs = 1'b0; r = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < NB; i++) hold[i] = $urandom_range(1, 40);
      repeat (3000) begin
         int unsigned op;
         logic [1:0]  a;
         @(negedge clk);
         cs = 1'b0; r = 1'b0; w = 1'b0; tb_oe = 1'b0;
         for (int i = 0; i < NB; i++) begin
            hold[i]--;
            if (hold[i] == 0) begin
               buttons[i] = ~buttons[i];
               hold[i] = $urandom_range(1, 40);
            end
         end
         op = $urandom_range(0, 7);
         a  = 2'($urandom_range(0, 3));
         if (op == 0) begin
            cs = 1'b1; w = 1'b1; addr = a; tb_wdata = 16'($urandom); tb_oe = 1'b1;
         end else if (op <= 3) begin
            rd_now("rand_read", a, mdl_read(a));
         end
      end
      @(negedge clk);
      cs = 1'b0; w = 1'b0; tb_oe = 1'b0;
      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/button_ctrl.md
Name: button_ctrl

Overview:
- Memory-mapped button input controller for the 0xB000 chip-select region; sits between the raw `buttons` pins and the CPU.
- Synchronises and debounces each button and latches press events in sticky flags.
- Raises a maskable level interrupt that drives `interrupts[7]` of the CPU.
- Software reads level and event registers over the shared 16-bit tri-state data bus.

Parameters:
- N_BUTTONS, 5, number of button inputs (max 8).
- DEBOUNCE_CYCLES, 16, consecutive clk cycles a changed level must persist before acceptance (≥2).
- CNT_W, 5, width of each per-button debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock (divided board clock); all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_bus  inout  16  shared CPU data bus; driven only during a selected read, else Z.
- address_bus  input  2  register select, CPU address bits [1:0].
- cs  input  1  chip select, address_bus[15:12]==4'hB decoded upstream.
- r  input  1  CPU read strobe.
- w  input  1  CPU write strobe; data sampled on the rising clk edge while cs&w.
- buttons  input  N_BUTTONS  raw asynchronous button pins, active-high.
- irq  output  1  interrupt request to CPU, level, active-high.

Behaviour:
- Register map (address_bus):
  - 0 LEVEL: RO, [N-1:0] debounced levels.
  - 1 EVENTS: [N-1:0] sticky press flags; write-1-to-clear.
  - 2 MASK: RW, [N-1:0] irq enables.
  - 3 ID: RO, constant 16'hB7C0.
  - Unused read bits return 0; writes to RO registers are ignored.
- Reset (reset low, async):
  - sync1, sync2, stable, counters, EVENTS, MASK all cleared.
  - irq=0 immediately; data_bus=Z.
- Synchroniser: two flops per button (sync1<=buttons, sync2<=sync1).
- Debounce, per button:
  - sync2==stable: counter<=0.
  - Otherwise counter increments.
  - When counter==DEBOUNCE_CYCLES-1 and mismatch persists: stable<=sync2, counter<=0.
  - Any return to equality before then restarts the count (glitch rejected).
- Latency: a clean input edge updates stable on clk edge 2+DEBOUNCE_CYCLES after the first edge that samples it.
- Press event: stable 0->1 sets the EVENTS bit on the same edge stable updates. Release does not set it, unless the optional feature is compiled in.
- EVENTS W1C: on cs&w to addr 1, bits written 1 clear. If set and clear hit the same bit on the same edge, set wins.
- irq is registered: irq<=|(EVENTS & MASK), asserted one edge after an event bit sets (or a MASK bit is written 1 over a pending event). It deasserts one edge after the clear/mask write.
- Read path is combinational: data_bus = cs&r ? selected register : 16'bz. The reading instruction sees the current register value.
- cs&r&w both high: write performed, bus still driven with the pre-write value.
- Counters saturate by construction; no wrap beyond DEBOUNCE_CYCLES-1.
- Reset mid-debounce discards the partial count; a button held through reset produces a press event 2+DEBOUNCE_CYCLES cycles after reset release.

Optional Feature:
- Macro: BUTTON_CTRL_RELEASE_EVT_EN.
- Defined:
  - stable 1->0 sets EVENTS bit [8+i].
  - Bits [8+N-1:8] are W1C like the press bits.
  - MASK bits [8+N-1:8] enable release irq.
  - irq = |(EVENTS & MASK) over both halves.
- Undefined: bits [15:8] of EVENTS and MASK read 0, ignore writes, and never raise irq.

Test Plan:
- Reset check: assert reset low mid-run with MASK=5'h1F and EVENTS=5'h03 -> irq=0 asynchronously; all registers read 0; ID reads 16'hB7C0.
- Clean press: buttons[2] 0->1 held 40 cycles, DEBOUNCE_CYCLES=16, MASK=5'h04 -> LEVEL reads 5'h04 and EVENTS bit2 set exactly 18 edges after sampling; irq high 1 edge later.
- Glitch rejection: pulse buttons[0] high for 10 cycles, then low -> LEVEL stays 0, EVENTS stays 0, irq stays 0.
- Mask gating: event on buttons[1] with MASK=0 -> irq=0. Then write MASK=5'h02 -> irq=1 next edge. Write EVENTS=5'h02 -> EVENTS reads 0 and irq=0 next edge.
- Set/clear collision: W1C of bit3 on the same edge stable[3] rises -> EVENTS bit3 remains 1.
- Bus discipline: cs=0 or r=0 -> data_bus Z. Simultaneous cs&r&w to MASK (old 5'h01, write 5'h1F) -> bus shows 16'h0001 that cycle, 16'h001F afterwards.
